// File: rtl/vector_instr_sequencer_if.sv
// Host-side bundle for vector_instr_sequencer: program write port, run control and issue outputs.
// master = host/testbench side, slave = sequencer side.
interface vector_instr_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [12:0]       prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic [12:0]       instruct;
    logic              issue_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start,
        input  instruct, issue_valid, busy, done, pc
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start,
        output instruct, issue_valid, busy, done, pc
    );
endinterface

// File: rtl/vector_instr_sequencer.sv
// Issues a stored program on instruct, holding each word for a class-dependent number of cycles.
// Optional HAZARD_STALL_EN macro stretches the hold of an instruction that feeds the next one.
module vector_instr_sequencer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int HOLD_MEM   = 2,
    parameter int HOLD_ALU   = 3,
    parameter int HAZARD_GAP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    vector_instr_sequencer_if.slave  bus
);
    // Counter wide enough for the longest possible stretched hold.
    localparam int CNT_W = $clog2(HOLD_MEM + HOLD_ALU + HAZARD_GAP + 1) + 1;
    localparam logic [CNT_W-1:0]  L_HOLD_MEM = CNT_W'(HOLD_MEM);
    localparam logic [CNT_W-1:0]  L_HOLD_ALU = CNT_W'(HOLD_ALU);
    localparam logic [CNT_W-1:0]  L_CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   L_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L_LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] L_PC_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [12:0]       r_mem [DEPTH];
    logic [12:0]       r_instruct;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W:0]   r_len, w_len_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_zero_done, w_zero_done_nxt;
    logic              w_fetch;
    logic              w_end_instr;
    logic              w_last;
    logic              w_busy;
    logic [CNT_W-1:0]  w_base;
    logic [CNT_W-1:0]  w_total;

    assign w_busy = (r_state == S_ISSUE) || (r_state == S_HOLD);
    assign w_last = ({1'b0, r_pc} == (r_len - L_LEN_ONE));
    assign w_base = r_instruct[12] ? L_HOLD_ALU : L_HOLD_MEM;

`ifdef HAZARD_STALL_EN
    localparam logic [CNT_W-1:0] L_GAP = CNT_W'(HAZARD_GAP);
    logic [12:0] w_nxt_word;
    logic        w_has_next;
    logic        w_dep;
    logic        w_cur_ld, w_cur_alu, w_nxt_st, w_nxt_alu;

    assign w_nxt_word = r_mem[r_pc + L_PC_ONE];
    assign w_has_next = (({1'b0, r_pc} + L_LEN_ONE) < r_len);
    assign w_cur_ld   = !r_instruct[12] && !r_instruct[11];
    assign w_cur_alu  = r_instruct[12];
    assign w_nxt_st   = !w_nxt_word[12] && w_nxt_word[11];
    assign w_nxt_alu  = w_nxt_word[12];
    // load->store same reg, load r0/r1->ALU, ALU->store r2/r3
    assign w_dep = (w_cur_ld && w_nxt_st && (r_instruct[10:9] == w_nxt_word[10:9]))
                || (w_cur_ld && !r_instruct[10] && w_nxt_alu)
                || (w_cur_alu && w_nxt_st && w_nxt_word[10]);
    assign w_total = w_base + ((w_dep && w_has_next) ? L_GAP : '0);
`else
    assign w_total = w_base;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_zero_done_nxt = 1'b0;
        w_fetch         = 1'b0;
        w_end_instr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.prog_len == '0) begin
                        w_zero_done_nxt = 1'b1;
                    end else begin
                        w_len_nxt   = (bus.prog_len > L_DEPTH) ? L_DEPTH : bus.prog_len;
                        w_pc_nxt    = '0;
                        w_state_nxt = S_ISSUE;
                        w_fetch     = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (w_total == L_CNT_ONE) begin
                    w_end_instr = 1'b1;
                end else begin
                    w_cnt_nxt   = w_total - L_CNT_ONE;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_cnt_nxt = r_cnt - L_CNT_ONE;
                if (r_cnt == L_CNT_ONE) begin
                    w_end_instr = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_end_instr) begin
            if (w_last) begin
                w_state_nxt = S_DONE;
            end else begin
                w_pc_nxt    = r_pc + L_PC_ONE;
                w_state_nxt = S_ISSUE;
                w_fetch     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_instruct  <= '0;
            r_pc        <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_zero_done <= w_zero_done_nxt;
            if (w_fetch) begin
                r_instruct <= r_mem[w_pc_nxt];
            end
        end
    end

    // Program store survives reset; writes only land while no run is in flight.
    always_ff @(posedge clk) begin
        if (bus.prog_we && !w_busy) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.instruct    = r_instruct;
    assign bus.issue_valid = (r_state == S_ISSUE);
    assign bus.busy        = w_busy;
    assign bus.done        = (r_state == S_DONE) || r_zero_done;
    assign bus.pc          = r_pc;
endmodule

// File: tb/tb_vector_instr_sequencer.sv
// Directed bench for vector_instr_sequencer: program vectors table plus hand-written corner sequences.
module tb_vector_instr_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    vector_instr_sequencer_if #(.ADDR_W(4)) bus ();

    vector_instr_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               nw;
        logic [4:0]       len;
        logic [15:0][12:0] words;
        logic [15:0][7:0]  iss;
        int               done_at;
        bit               disturb;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_prog(input vec_t v);
        for (int i = 0; i < v.nw; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'(i);
            bus.prog_data = v.words[i];
            step();
        end
        bus.prog_we = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int  idx;
        bit  got_done;
        load_prog(v);
        bus.prog_len = v.len;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        idx = 0;
        got_done = 1'b0;
        for (int c = 1; c <= 60 && !got_done; c++) begin
            if (bus.issue_valid) begin
                chk($sformatf("v%0d issue%0d cycle", id, idx), 32'(c), 32'(v.iss[idx]));
                chk($sformatf("v%0d issue%0d pc", id, idx), 32'(bus.pc), 32'(idx));
                chk($sformatf("v%0d issue%0d instruct", id, idx), 32'(bus.instruct), 32'(v.words[idx]));
                idx++;
            end
            chk($sformatf("v%0d busy c%0d", id, c), 32'(bus.busy), 32'(c < v.done_at));
            if (bus.done) begin
                chk($sformatf("v%0d done cycle", id), 32'(c), 32'(v.done_at));
                got_done = 1'b1;
                // start during the done cycle must be ignored
                bus.start = 1'b1;
            end else if (v.disturb && c == 2) begin
                bus.start     = 1'b1;
                bus.prog_we   = 1'b1;
                bus.prog_addr = 4'd2;
                bus.prog_data = 13'h1FFF;
            end
            step();
            bus.start   = 1'b0;
            bus.prog_we = 1'b0;
        end
        chk($sformatf("v%0d done seen", id), 32'(got_done), 32'd1);
        chk($sformatf("v%0d issue count", id), 32'(idx), 32'(v.nw));
        chk($sformatf("v%0d post issue_valid", id), 32'(bus.issue_valid), 32'd0);
        chk($sformatf("v%0d post busy", id), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d post done", id), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d post instruct", id), 32'(bus.instruct), 32'(v.words[v.nw-1]));
        step();
    endtask

    initial begin
        int  cnt_iv;
        int  cnt_dn;
        vec_t v;

        // vector 0: four-instruction program with two dependencies
        vecs[0].nw = 4; vecs[0].len = 5'd4; vecs[0].disturb = 1'b0;
        vecs[0].words[0] = 13'h0005; vecs[0].words[1] = 13'h0206;
        vecs[0].words[2] = 13'h1000; vecs[0].words[3] = 13'h0C07;
`ifdef HAZARD_STALL_EN
        vecs[0].iss[0] = 8'd1; vecs[0].iss[1] = 8'd3; vecs[0].iss[2] = 8'd6; vecs[0].iss[3] = 8'd10;
        vecs[0].done_at = 12;
`else
        vecs[0].iss[0] = 8'd1; vecs[0].iss[1] = 8'd3; vecs[0].iss[2] = 8'd5; vecs[0].iss[3] = 8'd8;
        vecs[0].done_at = 10;
`endif
        // vector 1: load r1 then store r1
        vecs[1].nw = 2; vecs[1].len = 5'd2; vecs[1].disturb = 1'b0;
        vecs[1].words[0] = 13'h0203; vecs[1].words[1] = 13'h0A04;
`ifdef HAZARD_STALL_EN
        vecs[1].iss[0] = 8'd1; vecs[1].iss[1] = 8'd4; vecs[1].done_at = 6;
`else
        vecs[1].iss[0] = 8'd1; vecs[1].iss[1] = 8'd3; vecs[1].done_at = 5;
`endif
        // vector 2: load r0 then store r1, independent
        vecs[2].nw = 2; vecs[2].len = 5'd2; vecs[2].disturb = 1'b0;
        vecs[2].words[0] = 13'h0003; vecs[2].words[1] = 13'h0A04;
        vecs[2].iss[0] = 8'd1; vecs[2].iss[1] = 8'd3; vecs[2].done_at = 5;
        // vector 3: single ALU word
        vecs[3].nw = 1; vecs[3].len = 5'd1; vecs[3].disturb = 1'b0;
        vecs[3].words[0] = 13'h1800; vecs[3].iss[0] = 8'd1; vecs[3].done_at = 4;
        // vector 4: length above DEPTH clamps to 16 loads
        vecs[4].nw = 16; vecs[4].len = 5'd20; vecs[4].disturb = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vecs[4].words[i] = 13'h0001;
            vecs[4].iss[i]   = 8'(1 + 2*i);
        end
        vecs[4].done_at = 33;
        // vector 5: vector 0 with start/prog_we poked mid-run
        vecs[5] = vecs[0];
        vecs[5].disturb = 1'b1;

        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.prog_len = '0; bus.start = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst instruct", 32'(bus.instruct), 32'h0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst pc", 32'(bus.pc), 32'd0);

        // zero-length start: done next cycle, never issues
        bus.prog_len = '0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("len0 done", 32'(bus.done), 32'd1);
        chk("len0 issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("len0 busy", 32'(bus.busy), 32'd0);
        step();
        chk("len0 done clears", 32'(bus.done), 32'd0);
        chk("len0 issue_valid later", 32'(bus.issue_valid), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(k, vecs[k]);
        end

        // reset in the middle of a run
        v = vecs[0];
        load_prog(v);
        bus.prog_len = v.len;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        chk("midrst busy before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst instruct", 32'(bus.instruct), 32'h0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("midrst pc", 32'(bus.pc), 32'd0);
        cnt_iv = 0;
        cnt_dn = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.issue_valid) cnt_iv++;
            if (bus.done) cnt_dn++;
        end
        chk("midrst no issue after", 32'(cnt_iv), 32'd0);
        chk("midrst no done after", 32'(cnt_dn), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
